// File: rtl/genius_pkg.sv
// Shared types and constants for the GENIUS sequence player.
package genius_pkg;

  // Default sequence memory depth (maximum number of rounds)
  localparam int unsigned DEF_MAX_LEN = 16;

  // Colour codes as seen on the lamp mux select
  localparam logic [1:0] COL_GREEN  = 2'b00;
  localparam logic [1:0] COL_RED    = 2'b01;
  localparam logic [1:0] COL_YELLOW = 2'b10;
  localparam logic [1:0] COL_BLUE   = 2'b11;

  // Player FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ON   = 2'd1;
  localparam state_t ST_OFF  = 2'd2;

endpackage

// File: rtl/genius_seq_mem.sv
// Colour sequence register file: synchronous write, asynchronous read, no reset.
module genius_seq_mem
  import genius_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_MAX_LEN,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [1:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [1:0]    rdata_o
);

  logic [1:0] mem_q [DEPTH];

  // Write port; contents survive reset on purpose
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/genius_seq_player.sv
// Steps the lamp mux select through the stored colour sequence with timed on/off phases.
module genius_seq_player
  import genius_pkg::*;
#(
  parameter int unsigned MAX_LEN = DEF_MAX_LEN,
  parameter int unsigned T_ON    = 4,
  parameter int unsigned T_OFF   = 2,
  localparam int unsigned AW     = $clog2(MAX_LEN),
  localparam int unsigned LW     = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [LW-1:0] len_i,
  input  logic          seq_we_i,
  input  logic [AW-1:0] seq_addr_i,
  input  logic [1:0]    seq_data_i,
  output logic [1:0]    sel_o,
  output logic          led_en_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [AW-1:0] step_idx_o
);

  localparam int unsigned TMAX = (T_ON > T_OFF) ? T_ON : T_OFF;
  localparam int unsigned CW   = $clog2(TMAX) + 1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] last_q, last_d;
  logic [1:0]    sel_q, sel_d;
  logic          led_q, led_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          mem_we_c;
  logic [AW-1:0] rd_addr_c;
  logic [1:0]    mem_rd_c;
  logic [1:0]    rd_data_c;

  // Writes only land while idle; reads look at the colour that will be shown next
  assign mem_we_c  = seq_we_i && (state_q == ST_IDLE);
  assign rd_addr_c = (state_q == ST_IDLE) ? '0 : idx_q + AW'(1);
  // Forward a same-cycle write so START sees the colour written alongside it
  assign rd_data_c = (mem_we_c && (seq_addr_i == rd_addr_c)) ? seq_data_i : mem_rd_c;

  genius_seq_mem #(
    .DEPTH (MAX_LEN)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (mem_we_c),
    .waddr_i (seq_addr_i),
    .wdata_i (seq_data_i),
    .raddr_i (rd_addr_c),
    .rdata_o (mem_rd_c)
  );

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      sel_q   <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic; outputs describe the state being entered
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    last_d  = last_q;
    sel_d   = sel_q;
    led_d   = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i && !abort_i) begin
          if (len_i == LW'(0)) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_ON;
            cnt_d   = '0;
            idx_d   = '0;
            last_d  = (len_i >= LW'(MAX_LEN)) ? AW'(MAX_LEN - 1) : AW'(len_i - LW'(1));
            sel_d   = rd_data_c;
            led_d   = 1'b1;
            busy_d  = 1'b1;
          end
        end
      end
      ST_ON: begin
        busy_d = 1'b1;
        if (cnt_q == CW'(T_ON - 1)) begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
          led_d = 1'b1;
        end
      end
      ST_OFF: begin
        busy_d = 1'b1;
        if (cnt_q == CW'(T_OFF - 1)) begin
          cnt_d = '0;
          if (idx_q == last_q) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ON;
            idx_d   = idx_q + AW'(1);
            sel_d   = rd_data_c;
            led_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Abort overrides whatever phase transition was due this cycle
    if (abort_i && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      led_d   = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  assign sel_o      = sel_q;
  assign led_en_o   = led_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign step_idx_o = idx_q;

endmodule

// File: tb/tb_genius_seq_player.sv
// Directed self-checking bench for genius_seq_player (MAX_LEN=16, T_ON=4, T_OFF=2).
module tb_genius_seq_player;

  localparam int unsigned PER = 6;  // T_ON + T_OFF

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic       abort_i;
  logic [4:0] len_i;
  logic       seq_we_i;
  logic [3:0] seq_addr_i;
  logic [1:0] seq_data_i;
  logic [1:0] sel_o;
  logic       led_en_o;
  logic       busy_o;
  logic       done_o;
  logic [3:0] step_idx_o;

  logic [1:0] exp_mem [16];
  int n_chk  = 0;
  int n_pass = 0;

  genius_seq_player #(
    .MAX_LEN (16),
    .T_ON    (4),
    .T_OFF   (2)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .len_i      (len_i),
    .seq_we_i   (seq_we_i),
    .seq_addr_i (seq_addr_i),
    .seq_data_i (seq_data_i),
    .sel_o      (sel_o),
    .led_en_o   (led_en_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .step_idx_o (step_idx_o)
  );

  always #5 clk_i = ~clk_i;

  // Observed output bundle {sel, led_en, busy, done, step_idx}
  function automatic logic [8:0] obs();
    return {sel_o, led_en_o, busy_o, done_o, step_idx_o};
  endfunction

  function automatic logic [8:0] pack(input logic [1:0] sel, input logic led, input logic busy,
                                      input logic done, input logic [3:0] idx);
    return {sel, led, busy, done, idx};
  endfunction

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got {sel,led,busy,done,idx}=%b want %b", tag, got, want);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input int addr, input logic [1:0] data);
    seq_we_i   = 1'b1;
    seq_addr_i = 4'(addr);
    seq_data_i = data;
    step();
    seq_we_i = 1'b0;
    exp_mem[addr] = data;
  endtask

  // Pulse START; on return the first ON cycle is visible
  task automatic start_play(input int len);
    len_i   = 5'(len);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  // Check every cycle of an n-step playback, then the DONE pulse and the cycle after it
  task automatic run_play(input int n, input bit disturb, input string tag);
    for (int k = 0; k < n * int'(PER); k++) begin
      int s;
      int ph;
      s  = k / int'(PER);
      ph = k % int'(PER);
      check($sformatf("%s k%0d", tag, k), obs(),
            pack(exp_mem[s], 1'(ph < 4), 1'b1, 1'b0, 4'(s)));
      if (disturb) begin
        start_i    = (k % 3 == 1);
        seq_we_i   = (k % 3 == 1);
        seq_addr_i = 4'(k % 16);
        seq_data_i = ~exp_mem[k % 16];
        len_i      = 5'd1;
      end
      step();
    end
    start_i  = 1'b0;
    seq_we_i = 1'b0;
    check({tag, " done"}, obs(), pack(exp_mem[n-1], 1'b0, 1'b0, 1'b1, 4'(n-1)));
    step();
    check({tag, " post"}, obs(), pack(exp_mem[n-1], 1'b0, 1'b0, 1'b0, 4'(n-1)));
  endtask

  initial begin
    rst_i      = 1'b1;
    start_i    = 1'b0;
    abort_i    = 1'b0;
    len_i      = '0;
    seq_we_i   = 1'b0;
    seq_addr_i = '0;
    seq_data_i = '0;
    for (int i = 0; i < 16; i++) exp_mem[i] = 2'b00;
    step();
    step();
    check("reset", obs(), 9'd0);
    rst_i = 1'b0;
    step();
    check("idle after reset", obs(), 9'd0);

    // Basic four-step playback 3,1,0,2
    wr(0, 2'd3);
    wr(1, 2'd1);
    wr(2, 2'd0);
    wr(3, 2'd2);
    start_play(4);
    run_play(4, 1'b0, "basic");

    // LEN=0: immediate DONE, never busy
    start_play(0);
    check("len0 done", obs(), pack(2'd2, 1'b0, 1'b0, 1'b1, 4'd3));
    step();
    check("len0 post", obs(), pack(2'd2, 1'b0, 1'b0, 1'b0, 4'd3));

    // ABORT together with START in IDLE: start ignored
    abort_i = 1'b1;
    start_play(4);
    abort_i = 1'b0;
    check("abort+start idle", obs(), pack(2'd2, 1'b0, 1'b0, 1'b0, 4'd3));

    // Fill whole memory with a varied pattern
    for (int i = 0; i < 16; i++) wr(i, 2'((i * 5 + (i >> 2) + 3) & 3));

    // START/SEQ_WE/LEN disturbance during playback is ignored
    start_play(4);
    run_play(4, 1'b1, "disturb");

    // LEN beyond MAX_LEN clamps to 16; also re-reads all memory after ignored writes
    start_play(20);
    run_play(16, 1'b0, "clamp");

    // ABORT in 2nd ON cycle of step 1
    start_play(4);
    for (int k = 0; k < 7; k++) step();
    check("pre-abort", obs(), pack(exp_mem[1], 1'b1, 1'b1, 1'b0, 4'd1));
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    check("abort", obs(), pack(exp_mem[1], 1'b0, 1'b0, 1'b0, 4'd1));
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("abort quiet %0d", k), obs(), pack(exp_mem[1], 1'b0, 1'b0, 1'b0, 4'd1));
    end
    start_play(4);
    run_play(4, 1'b0, "replay");

    // ABORT on the final OFF cycle beats the DONE transition
    start_play(1);
    for (int k = 0; k < 5; k++) step();
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    check("abort last", obs(), pack(exp_mem[0], 1'b0, 1'b0, 1'b0, 4'd0));

    // RST at step 2 clears outputs but keeps memory
    start_play(4);
    for (int k = 0; k < 12; k++) step();
    check("pre-rst", obs(), pack(exp_mem[2], 1'b1, 1'b1, 1'b0, 4'd2));
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("mid rst", obs(), 9'd0);
    start_play(4);
    run_play(4, 1'b0, "after rst");

    // Write mem[0] and START in the same cycle
    seq_we_i   = 1'b1;
    seq_addr_i = 4'd0;
    seq_data_i = 2'd2;
    start_play(1);
    seq_we_i   = 1'b0;
    exp_mem[0] = 2'd2;
    run_play(1, 1'b0, "wr+start");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
